// File: rtl/rf_wb_arbiter_pkg.sv
// ============================================================================
// rf_wb_arbiter_pkg : widths, write-enable encodings and lane-mask helper
// Revision 1.0
// ============================================================================
`default_nettype none

package rf_wb_arbiter_pkg;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;
  localparam int unsigned LANE_W = DATA_W / BE_W;

  localparam logic [BE_W-1:0] WEN_NONE = 2'b00;
  localparam logic [BE_W-1:0] WEN_LO   = 2'b01;
  localparam logic [BE_W-1:0] WEN_HI   = 2'b10;
  localparam logic [BE_W-1:0] WEN_WORD = 2'b11;

  // Expands byte enables into a bit mask over the data word.
  function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      m[i*LANE_W +: LANE_W] = {LANE_W{be[i]}};
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
// rf_wb_arbiter_if : two writeback requesters plus register-file write port
// Revision 1.0
// ============================================================================
`default_nettype none

interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [IDX_W-1:0]  a_dest;
  logic [DATA_W-1:0] a_data;
  logic [BE_W-1:0]   a_be;

  logic              b_valid;
  logic              b_ready;
  logic [IDX_W-1:0]  b_dest;
  logic [DATA_W-1:0] b_data;
  logic [BE_W-1:0]   b_be;

  logic [IDX_W-1:0]  d;
  logic [DATA_W-1:0] wr;
  logic [BE_W-1:0]   w_en;
  logic              prio_b;

  modport slave (
    input  a_valid, a_dest, a_data, a_be,
    input  b_valid, b_dest, b_data, b_be,
    output a_ready, b_ready, d, wr, w_en, prio_b
  );

  modport master (
    output a_valid, a_dest, a_data, a_be,
    output b_valid, b_dest, b_data, b_be,
    input  a_ready, b_ready, d, wr, w_en, prio_b
  );

endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_pick2.sv
// ============================================================================
// rf_wb_arbiter_rr_pick2 : 2-way round-robin select from valids and pointer
// Revision 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter_rr_pick2 (
  input  wire logic valid_a_i,
  input  wire logic valid_b_i,
  input  wire logic prio_b_i,
  output logic      grant_a_o,
  output logic      grant_b_o
);

  assign grant_a_o = valid_a_i & (~valid_b_i | ~prio_b_i);
  assign grant_b_o = valid_b_i & (~valid_a_i |  prio_b_i);

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// rf_wb_arbiter : round-robin register-file writeback arbiter with byte merge
// Revision 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  rf_wb_arbiter_if.slave  bus
);

  logic              grant_a;
  logic              grant_b;
  logic              merge;

  logic [IDX_W-1:0]  d_q,      d_d;
  logic [DATA_W-1:0] wr_q,     wr_d;
  logic [BE_W-1:0]   w_en_q,   w_en_d;
  logic              prio_b_q, prio_b_d;

  rf_wb_arbiter_rr_pick2 u_pick (
    .valid_a_i (bus.a_valid),
    .valid_b_i (bus.b_valid),
    .prio_b_i  (prio_b_q),
    .grant_a_o (grant_a),
    .grant_b_o (grant_b)
  );

  // Disjoint, non-empty byte enables to the same register fold into one write.
  assign merge = bus.a_valid & bus.b_valid
               & (bus.a_dest == bus.b_dest)
               & (|bus.a_be) & (|bus.b_be)
               & ~(|(bus.a_be & bus.b_be));

  assign bus.a_ready = rst_n & (merge | grant_a);
  assign bus.b_ready = rst_n & (merge | grant_b);

  always_comb begin
    d_d      = d_q;
    wr_d     = wr_q;
    w_en_d   = WEN_NONE;
    prio_b_d = prio_b_q;
    if (merge) begin
      d_d    = bus.a_dest;
      wr_d   = (bus.a_data & be_mask(bus.a_be)) | (bus.b_data & be_mask(bus.b_be));
      w_en_d = bus.a_be | bus.b_be;
    end else if (grant_a) begin
      d_d      = bus.a_dest;
      wr_d     = bus.a_data & be_mask(bus.a_be);
      w_en_d   = bus.a_be;
      prio_b_d = 1'b1;
    end else if (grant_b) begin
      d_d      = bus.b_dest;
      wr_d     = bus.b_data & be_mask(bus.b_be);
      w_en_d   = bus.b_be;
      prio_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q      <= '0;
      wr_q     <= '0;
      w_en_q   <= WEN_NONE;
      prio_b_q <= 1'b0;
    end else begin
      d_q      <= d_d;
      wr_q     <= wr_d;
      w_en_q   <= w_en_d;
      prio_b_q <= prio_b_d;
    end
  end

  assign bus.d      = d_q;
  assign bus.wr     = wr_q;
  assign bus.w_en   = w_en_q;
  assign bus.prio_b = prio_b_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// tb_rf_wb_arbiter : directed vectors with a queued scoreboard for rf_wb_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_rf_wb_arbiter;

  typedef struct {
    logic [2:0]  d;
    logic [15:0] wr;
    logic [1:0]  wen;
    logic        prio;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares registered outputs one step after every edge that has an expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("out_d",    32'(bus.d),      32'(e.d));
      chk("out_wr",   32'(bus.wr),     32'(e.wr));
      chk("out_wen",  32'(bus.w_en),   32'(e.wen));
      chk("out_prio", 32'(bus.prio_b), 32'(e.prio));
    end
  end

  // Drives one cycle at a negedge, checks readies, queues the post-edge result.
  task automatic cyc(
    input logic av, input logic [2:0] ad, input logic [15:0] adat, input logic [1:0] abe,
    input logic bv, input logic [2:0] bd, input logic [15:0] bdat, input logic [1:0] bbe,
    input logic ear, input logic ebr, input logic eprio_pre,
    input logic [2:0] ed, input logic [15:0] ewr, input logic [1:0] ewen, input logic eprio);
    exp_t e;
    bus.a_valid = av; bus.a_dest = ad; bus.a_data = adat; bus.a_be = abe;
    bus.b_valid = bv; bus.b_dest = bd; bus.b_data = bdat; bus.b_be = bbe;
    #1;
    chk("a_ready",  32'(bus.a_ready), 32'(ear));
    chk("b_ready",  32'(bus.b_ready), 32'(ebr));
    chk("prio_pre", 32'(bus.prio_b),  32'(eprio_pre));
    e.d = ed; e.wr = ewr; e.wen = ewen; e.prio = eprio;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.a_valid = 1'b1; bus.a_dest = 3'd1; bus.a_data = 16'h5A5A; bus.a_be = 2'b11;
    bus.b_valid = 1'b0; bus.b_dest = 3'd0; bus.b_data = 16'h0000; bus.b_be = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
    chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
    chk("rst_wen",     32'(bus.w_en),    32'd0);
    chk("rst_prio",    32'(bus.prio_b),  32'd0);
    chk("rst_d",       32'(bus.d),       32'd0);
    chk("rst_wr",      32'(bus.wr),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A alone on the first edge after release
    cyc(1, 3'd1, 16'h5A5A, 2'b11, 0, 3'd0, 16'h0000, 2'b00, 1, 0, 0, 3'd1, 16'h5A5A, 2'b11, 1);
    // B alone with zero enables: granted, no write, pointer moves back to A
    cyc(0, 3'd0, 16'h0000, 2'b00, 1, 3'd6, 16'hFFFF, 2'b00, 0, 1, 1, 3'd6, 16'h0000, 2'b00, 0);
    // Sustained contention alternates A, B, A
    cyc(1, 3'd3, 16'h1234, 2'b11, 1, 3'd5, 16'hABCD, 2'b11, 1, 0, 0, 3'd3, 16'h1234, 2'b11, 1);
    cyc(1, 3'd3, 16'h1234, 2'b11, 1, 3'd5, 16'hABCD, 2'b11, 0, 1, 1, 3'd5, 16'hABCD, 2'b11, 0);
    cyc(1, 3'd3, 16'h1234, 2'b11, 1, 3'd5, 16'hABCD, 2'b11, 1, 0, 0, 3'd3, 16'h1234, 2'b11, 1);
    // Idle: no write, d/wr hold
    cyc(0, 3'd0, 16'h0000, 2'b00, 0, 3'd0, 16'h0000, 2'b00, 0, 0, 1, 3'd3, 16'h1234, 2'b00, 1);
    // Merges: pointer unchanged, disabled-lane data dropped
    cyc(1, 3'd2, 16'h00EE, 2'b01, 1, 3'd2, 16'h7700, 2'b10, 1, 1, 1, 3'd2, 16'h77EE, 2'b11, 1);
    cyc(1, 3'd7, 16'hABCD, 2'b10, 1, 3'd7, 16'h1234, 2'b01, 1, 1, 1, 3'd7, 16'hAB34, 2'b11, 1);
    // Overlapping enables: separate writes, B first since it holds priority
    cyc(1, 3'd4, 16'hCAFE, 2'b11, 1, 3'd4, 16'hBEEF, 2'b01, 0, 1, 1, 3'd4, 16'h00EF, 2'b01, 0);
    cyc(1, 3'd4, 16'hCAFE, 2'b11, 0, 3'd4, 16'hBEEF, 2'b01, 1, 0, 0, 3'd4, 16'hCAFE, 2'b11, 1);
    // High byte only
    cyc(1, 3'd0, 16'h1234, 2'b10, 0, 3'd0, 16'h0000, 2'b00, 1, 0, 1, 3'd0, 16'h1200, 2'b10, 1);
    // Different dests with disjoint enables must not merge
    cyc(1, 3'd1, 16'h00AA, 2'b01, 1, 3'd2, 16'hBB00, 2'b10, 0, 1, 1, 3'd2, 16'hBB00, 2'b10, 0);

    // Reset right after a handshake edge discards the pending write
    bus.a_valid = 1'b1; bus.a_dest = 3'd5; bus.a_data = 16'h5555; bus.a_be = 2'b11;
    bus.b_valid = 1'b0;
    #1;
    chk("mid_a_ready", 32'(bus.a_ready), 32'd1);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_wen",     32'(bus.w_en),    32'd0);
    chk("mid_d",       32'(bus.d),       32'd0);
    chk("mid_wr",      32'(bus.wr),      32'd0);
    chk("mid_prio",    32'(bus.prio_b),  32'd0);
    chk("mid_a_ready0", 32'(bus.a_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 3'd0, 16'h0000, 2'b00, 0, 3'd0, 16'h0000, 2'b00, 0, 0, 0, 3'd0, 16'h0000, 2'b00, 0);
    cyc(1, 3'd5, 16'h5555, 2'b11, 0, 3'd0, 16'h0000, 2'b00, 1, 0, 0, 3'd5, 16'h5555, 2'b11, 1);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL provide the following ports: one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 a_valid  in  1  requester A (ALU writeback) has a write pending.
REQ-005 a_ready  out  1  A's request accepted this cycle.
REQ-006 a_dest  in  3  A destination register index 0..7.
REQ-007 a_data  in  16  A write data.
REQ-008 a_be  in  2  A byte enables: bit1 = [15:8], bit0 = [7:0].
REQ-009 b_valid, b_ready, b_dest, b_data, b_be SHALL mirror REQ-004..008 for requester B (load writeback).
REQ-010 d  out  3  register file destination index.
REQ-011 wr  out  16  register file write data.
REQ-012 w_en  out  2  register file byte-lane write enable; 11 = word, 01 = low byte, 10 = high byte, 00 = no write.
REQ-013 prio_b  out  1  round-robin pointer; 1 = B currently has priority.

Function
REQ-014 Handshake: a request SHALL transfer on any posedge where valid and ready are both 1; ready is combinational from the current valids, dests, be and prio_b.
REQ-015 A requester SHALL hold valid, dest, data and be stable until ready; the block need not tolerate withdrawal.
REQ-016 Single valid: that requester SHALL get ready=1 in the same cycle.
REQ-017 Both valid, no merge: the requester selected by prio_b SHALL get ready=1; the other SHALL get ready=0.
REQ-018 Merge condition: both valid, a_dest==b_dest, a_be and b_be both nonzero, (a_be & b_be)==00.
REQ-019 On merge, both ready SHALL be 1 and one write SHALL issue with w_en = a_be|b_be; each lane of wr comes from the requester enabling it.
REQ-020 After a single grant, prio_b SHALL point to the non-granted requester; after a merge or an idle cycle, prio_b SHALL be unchanged.
REQ-021 Output latency: d, wr and w_en SHALL be registered and reflect the transfer one cycle after the handshake edge.
REQ-022 Outputs SHALL hold w_en=00 in every cycle with no transfer; d and wr hold their previous values.
REQ-023 A request with be=00 SHALL be accepted as a normal grant, update prio_b, and produce w_en=00.
REQ-024 Disabled lanes of wr SHALL be driven 0.
REQ-025 Throughput: at most one register-file write per cycle; sustained both-valid traffic alternates A, B, A, B.
REQ-026 Starvation: no valid requester SHALL wait more than 1 cycle.

Reset
REQ-027 While rst_n=0: a_ready=0, b_ready=0, w_en=00, d=0, wr=0, prio_b=0 (A first), applied asynchronously.
REQ-028 Reset asserted mid-operation SHALL discard any registered but unissued write; no w_en pulse follows reset release.
REQ-029 The first posedge after rst_n rises SHALL accept transfers normally.

Structure
REQ-030 The shared package SHALL hold the register-index width (3), data width (16), byte-enable width (2) and the w_en encodings WEN_NONE/LO/HI/WORD.
REQ-031 One sub-module SHALL be natural: rr_pick2 (2-way round-robin select from valids and prio_b); the merge logic and output register stay in the top.

Verification
REQ-032 Reset: hold rst_n=0 with a_valid=1 -> a_ready=0, w_en=00, prio_b=0; release -> A granted on the first edge.
REQ-033 Contention: A(dest 3, 0x1234, be 11) and B(dest 5, 0xABCD, be 11) held valid -> A granted first, B next cycle; outputs d=3/w_en=11/wr=1234, then d=5/wr=ABCD, prio_b toggles.
REQ-034 Merge: A(dest 2, 0x00EE, be 01) and B(dest 2, 0x7700, be 10) -> both ready the same cycle; next cycle d=2, w_en=11, wr=0x77EE, prio_b unchanged.
REQ-035 Overlap, no merge: A(dest 4, be 11) and B(dest 4, be 01) -> two separate writes in round-robin order, with B's wr[15:8]=0.
REQ-036 Zero enable: B only, be=00 -> b_ready=1, next cycle w_en=00, prio_b=0.
REQ-037 Mid-operation reset: assert rst_n=0 between a handshake edge and its issue -> no write is issued; all outputs take the reset values.
